// File: rtl/fetch_stage_pkg.sv
// Shared widths, FSM state encoding and queue entry layout for the fetch stage.
package fetch_stage_pkg;
    localparam int ADDR_W  = 11;
    localparam int INSTR_W = 29;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; head reads as zero when empty.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t wdata,
    output logic   full,
    output logic   empty,
    output entry_t head
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    entry_t            r_mem [QDEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty  = (r_count == '0);
    assign full   = (r_count == CNT_W'(QDEPTH));
    assign w_pop  = pop & ~empty;
    // A full queue can still take a push when the head leaves in the same cycle.
    assign w_push = push & (~full | w_pop);
    assign head   = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= wdata;
    end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, IDLE/RUN control, branch redirect and an
// instruction queue decoupling the ROM from downstream decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 11'h000,
    parameter int                QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_en,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic [ADDR_W-1:0]  AddrROM,
    input  logic [INSTR_W-1:0] DataROM,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    output state_e             state_dbg
);
    // Handshake: an entry transfers on a rising edge where instr_valid and
    // instr_ready are both 1; the head stays stable while valid and not ready.

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_capture;
    entry_t            w_head;
    entry_t            w_wdata;

    assign w_pop   = ~w_empty & instr_ready;
    assign w_wdata = '{pc: r_pc, instr: DataROM};

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_state_next = fetch_en ? S_RUN : S_IDLE;
        // Branch wins over capture; the flushed queue makes any pop moot.
        if (r_state == S_RUN && !branch_en && (!w_full || w_pop)) begin
            w_capture = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (branch_en) begin
            r_pc <= branch_addr;
        end else if (w_capture) begin
            r_pc <= r_pc + 1'b1;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_capture),
        .pop   (w_pop & ~branch_en),
        .flush (branch_en),
        .wdata (w_wdata),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

    assign AddrROM     = r_pc;
    assign instr_valid = ~w_empty;
    assign instr_out   = w_head.instr;
    assign pc_out      = w_head.pc;
    assign state_dbg   = r_state;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational ROM model.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         fetch_en;
    logic         branch_en;
    logic [10:0]  branch_addr;
    logic [10:0]  AddrROM;
    logic [28:0]  DataROM;
    logic [28:0]  instr_out;
    logic [10:0]  pc_out;
    logic         instr_valid;
    logic         instr_ready;
    state_e       state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_en    (fetch_en),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .AddrROM     (AddrROM),
        .DataROM     (DataROM),
        .instr_out   (instr_out),
        .pc_out      (pc_out),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: three fixed words, everything else 29'h03E00000 | addr.
    function automatic logic [28:0] rom(input logic [10:0] a);
        case (a)
            11'h000: rom = 29'h01400008;
            11'h001: rom = 29'h03440004;
            11'h005: rom = 29'h03000001;
            default: rom = {18'h07C00, a};
        endcase
    endfunction

    assign DataROM = rom(AddrROM);

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        branch_en   = 1'b0;
        branch_addr = 11'h000;
        instr_ready = 1'b0;
        ticks(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic branch(input logic [10:0] addr);
        branch_en   = 1'b1;
        branch_addr = addr;
        tick();
        branch_en   = 1'b0;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [10:0] pc,
                             input logic [28:0] ins);
        check({tag, ".valid"}, 32'(instr_valid), 32'(v));
        check({tag, ".pc"},    32'(pc_out),      32'(pc));
        check({tag, ".instr"}, 32'(instr_out),   32'(ins));
    endtask

    initial begin
        rst_n       = 1'b0;
        fetch_en    = 1'b0;
        branch_en   = 1'b0;
        branch_addr = 11'h000;
        instr_ready = 1'b0;
        #3;
        check_out("rst", 1'b0, 11'h000, 29'h0);
        check("rst.addr", 32'(AddrROM), 32'h0);
        check("rst.state", 32'(state_dbg), 32'(S_IDLE));
        do_reset();

        // Basic fetch: first instruction two edges after fetch_en rises.
        check("idle.addr", 32'(AddrROM), 32'h0);
        fetch_en = 1'b1; instr_ready = 1'b1;
        tick();
        check("e1.valid", 32'(instr_valid), 32'h0);
        check("e1.state", 32'(state_dbg), 32'(S_RUN));
        tick();
        check_out("e2", 1'b1, 11'h000, 29'h01400008);
        tick();
        check_out("e3", 1'b1, 11'h001, 29'h03440004);
        tick();
        check_out("e4", 1'b1, 11'h002, 29'h03E00002);

        // Back-pressure: queue fills with 0 and 1, PC stalls at 2.
        do_reset();
        fetch_en = 1'b1;
        ticks(4);
        check("bp.addr", 32'(AddrROM), 32'h2);
        check_out("bp.head", 1'b1, 11'h000, 29'h01400008);
        tick();
        check("bp.addr2", 32'(AddrROM), 32'h2);
        check_out("bp.hold", 1'b1, 11'h000, 29'h01400008);
        instr_ready = 1'b1;
        tick();
        check_out("bp.d1", 1'b1, 11'h001, 29'h03440004);
        tick();
        check_out("bp.d2", 1'b1, 11'h002, 29'h03E00002);
        tick();
        check_out("bp.d3", 1'b1, 11'h003, 29'h03E00003);

        // Branch with two entries queued.
        do_reset();
        fetch_en = 1'b1;
        ticks(3);
        branch(11'h005);
        check("br.valid", 32'(instr_valid), 32'h0);
        check("br.addr", 32'(AddrROM), 32'h5);
        tick();
        check_out("br.t", 1'b1, 11'h005, 29'h03000001);
        check("br.addr2", 32'(AddrROM), 32'h6);

        // Branch with a coincident pop, then PC wrap-around.
        instr_ready = 1'b1;
        branch(11'h7FE);
        check("wr.valid", 32'(instr_valid), 32'h0);
        tick();
        check_out("wr.0", 1'b1, 11'h7FE, 29'h03E007FE);
        tick();
        check_out("wr.1", 1'b1, 11'h7FF, 29'h03E007FF);
        tick();
        check_out("wr.2", 1'b1, 11'h000, 29'h01400008);
        tick();
        check_out("wr.3", 1'b1, 11'h001, 29'h03440004);

        // Drop fetch_en with two entries queued: drain, PC frozen.
        instr_ready = 1'b0;
        tick();
        fetch_en = 1'b0;
        tick();
        check("dr.state", 32'(state_dbg), 32'(S_IDLE));
        check("dr.addr0", 32'(AddrROM), 32'h3);
        check_out("dr.h0", 1'b1, 11'h001, 29'h03440004);
        instr_ready = 1'b1;
        tick();
        check_out("dr.h1", 1'b1, 11'h002, 29'h03E00002);
        check("dr.addr1", 32'(AddrROM), 32'h3);
        tick();
        check("dr.empty", 32'(instr_valid), 32'h0);
        check("dr.addr2", 32'(AddrROM), 32'h3);

        // Asynchronous reset mid-cycle with the queue full.
        fetch_en = 1'b1; instr_ready = 1'b0;
        ticks(3);
        check_out("ar.full", 1'b1, 11'h003, 29'h03E00003);
        check("ar.addr", 32'(AddrROM), 32'h5);
        #2;
        rst_n = 1'b0; fetch_en = 1'b0; instr_ready = 1'b1;
        #1;
        check_out("ar.now", 1'b0, 11'h000, 29'h0);
        check("ar.addrnow", 32'(AddrROM), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        check("ar.nofetch", 32'(instr_valid), 32'h0);
        check("ar.addrhold", 32'(AddrROM), 32'h0);

        // Branch while IDLE loads PC without fetching.
        branch(11'h7FF);
        check("ib.addr", 32'(AddrROM), 32'h7FF);
        tick();
        check("ib.valid", 32'(instr_valid), 32'h0);
        check("ib.addr2", 32'(AddrROM), 32'h7FF);
        fetch_en = 1'b1;
        ticks(2);
        check_out("ib.first", 1'b1, 11'h7FF, 29'h03E007FF);
        tick();
        check_out("ib.next", 1'b1, 11'h000, 29'h01400008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 11'h000, is the PC value loaded on reset.
REQ-002 Parameter QDEPTH, default 2, is the instruction queue depth in entries.
REQ-003 clk  input  1  Sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  Reset, asynchronous and active-low.
REQ-005 fetch_en  input  1  Level; 1 = fetch sequentially, 0 = stop issuing new fetches.
REQ-006 branch_en  input  1  One-cycle pulse; redirects fetch to branch_addr.
REQ-007 branch_addr  input  11  Branch target word address.
REQ-008 AddrROM  output  11  Instruction ROM address; equals the PC register, with no combinational path from any input.
REQ-009 DataROM  input  29  ROM word; combinational function of AddrROM in the same cycle.
REQ-010 instr_out  output  29  Queue-head instruction word.
REQ-011 pc_out  output  11  Address from which instr_out was fetched.
REQ-012 instr_valid  output  1  Queue non-empty; instr_out and pc_out are meaningful.
REQ-013 instr_ready  input  1  Downstream decode accepts the head entry when instr_valid is also 1.

Function
REQ-014 FSM states are IDLE and RUN.
- IDLE to RUN on a clock edge with fetch_en=1.
- RUN to IDLE on a clock edge with fetch_en=0.
REQ-015 A capture occurs in a cycle when all of the following hold:
- state is RUN;
- branch_en=0;
- the queue is not full, or a pop occurs in the same cycle.
REQ-016 On a capture, {PC, DataROM} is written to the queue tail and PC increments by 1 modulo 2048 (11'h7FF wraps to 11'h000).
REQ-017 A pop occurs when instr_valid=1 and instr_ready=1.
REQ-018 On a pop, the head entry is removed at the clock edge.
REQ-019 A capture and a pop in the same cycle leave the occupancy unchanged, including when the queue is full.
REQ-020 instr_out, pc_out and instr_valid are driven from registered queue state only, never combinationally from DataROM.
REQ-021 Latency: a capture at edge N makes that entry visible on the outputs after edge N if the queue was empty.
REQ-022 Consequence of REQ-021: the first instruction appears 2 edges after fetch_en rises from IDLE.
REQ-023 On branch_en=1 (any state), at the next edge:
- PC loads branch_addr;
- the queue is flushed to empty;
- there is no capture that cycle;
- a coincident pop is accepted by downstream but has no further effect.
REQ-024 branch_en has priority over capture and pop; the state transition of REQ-014 still applies in the same cycle.
REQ-025 In IDLE, queued entries continue to drain via pops; PC is held unless branch_en=1.
REQ-026 While the queue is full and no pop occurs, PC and AddrROM hold their value (stall).
REQ-027 While instr_valid=1 and instr_ready=0, instr_out and pc_out remain stable.

Reset
REQ-028 While rst_n=0, asynchronously:
- PC = RESET_PC;
- AddrROM = RESET_PC;
- state = IDLE;
- queue empty;
- instr_valid = 0;
- instr_out = 29'h0;
- pc_out = 11'h0.
REQ-029 Reset asserted mid-operation discards all queued entries and any pending branch.
REQ-030 The first capture after reset release requires fetch_en sampled 1.

Structure
REQ-031 A shared package holds:
- widths ADDR_W=11 and INSTR_W=29;
- the FSM state enumeration;
- the queue entry type {pc, instr}.
REQ-032 The queue is one sub-module, fetch_queue:
- synchronous FIFO of QDEPTH entries;
- ports: push, pop, flush, full, empty, head;
- same clock and reset as fetch_stage.
REQ-033 fetch_stage contains the PC register, the FSM and the capture/branch control logic.

Verification
REQ-034 Reset then fetch_en=1, instr_ready=1, ROM[0]=29'h01400008, ROM[1]=29'h03440004:
- cycle 2: instr_valid=1, instr_out=29'h01400008, pc_out=0;
- cycle 3: instr_out=29'h03440004, pc_out=1.
REQ-035 Run with instr_ready=0:
- queue fills with pc_out 0 and 1;
- AddrROM holds 2;
- instr_out stays 29'h01400008.
- Then raise instr_ready: entries 0, 1, 2 delivered in order, with no gap or duplicate.
REQ-036 branch_en=1, branch_addr=11'h005, with 2 entries queued:
- next cycle instr_valid=0 and AddrROM=5;
- following cycle instr_out=ROM[5]=29'h03000001, pc_out=5.
REQ-037 Branch to 11'h7FE, run with instr_ready=1:
- pc_out sequence is 7FE, 7FF, 000, 001.
REQ-038 Asynchronous rst_n low mid-cycle while the queue is full:
- instr_valid=0 and AddrROM=RESET_PC immediately, without waiting for a clock edge;
- after release, no fetch occurs until fetch_en=1.
REQ-039 Drop fetch_en with 2 entries queued and instr_ready=1:
- both entries drain;
- AddrROM is frozen;
- instr_valid falls afterwards.
